// File: rtl/gray_arb_pkg.sv
// Purpose: shared types and round-robin pick helper for the gray converter arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package gray_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Upper bound on requesters the pick helper can scan; callers zero-extend.
    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    // One-hot of the first set bit of valid at or after ptr, wrapping at n_req.
    // Returns all zeros when no bit below n_req is set.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input int unsigned           ptr,
        input int unsigned           n_req
    );
        logic [RR_MAX_REQ-1:0] grant;
        logic                  found;
        int unsigned           idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            if (k < n_req) begin
                idx = ptr + k;
                if (idx >= n_req) begin
                    idx = idx - n_req;
                end
                if (!found && valid[idx[RR_IDX_W-1:0]]) begin
                    grant[idx[RR_IDX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/gray_conv_core.sv
// Purpose: WIDTH-wide registered binary-to-Gray stage; captures only when load=1.
// Latency: 1 cycle from load to gray_out; holds its value otherwise.
// Backpressure: none; the caller decides when to load.
// Ports: clk, rst_n (sync, active-low, clears to 0), load, bin_in, gray_out.
module gray_conv_core
    import gray_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] bin_in,
    output logic [WIDTH-1:0] gray_out
);

    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    always_comb begin
        gray_d = gray_q;
        if (load) begin
            gray_d = bin_in ^ (bin_in >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign gray_out = gray_q;

endmodule

// File: rtl/gray_conv_arbiter.sv
// Purpose: round-robin shares one registered binary-to-Gray converter among N_REQ requesters.
// Latency: grant at cycle T -> rsp_valid at T+2; grants are at least 3 cycles apart.
// Backpressure: rsp_ready=0 holds the response and blocks further grants until accepted.
// Ports: clk, rst_n (sync active-low); req_valid/req_data/req_ready per requester
//        (req_ready is the one-hot grant); rsp_valid/rsp_data/rsp_id/rsp_ready result port.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready
);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [RR_MAX_REQ-1:0] pick_full;
    logic [N_REQ-1:0]      grant;
    logic                  any_grant;
    logic [ID_W-1:0]       grant_idx;
    logic [WIDTH-1:0]      operand_sel;
    logic                  conv_load;

    // Arbitration: combinational from req_valid and the rotating pointer.
    always_comb begin
        pick_full   = rr_pick(RR_MAX_REQ'(req_valid), 32'(rr_ptr_q), N_REQ);
        grant       = pick_full[N_REQ-1:0];
        any_grant   = |pick_full;
        grant_idx   = '0;
        operand_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
            end
            operand_sel = operand_sel | (req_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    // Grants only exist in IDLE and never while reset is held.
    assign req_ready = (rst_n && (state_q == IDLE)) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        operand_d   = operand_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (any_grant) begin
                    operand_d = operand_sel;
                    id_d      = grant_idx;
                    rr_ptr_d  = ID_W'((32'(grant_idx) + 32'd1) % N_REQ);
                    state_d   = CONV;
                end
            end
            CONV: begin
                // Converter captures this cycle; result is visible next cycle.
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign conv_load = (state_q == CONV);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            operand_q   <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            operand_q   <= operand_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    gray_conv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (conv_load),
        .bin_in   (operand_q),
        .gray_out (rsp_data)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;

endmodule
